mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the core's single-port synchronous memory between instruction fetch (IF) and load/store (LS).
//   Arbitrates requests, issues one access at a time and waits out the fixed memory read latency.
//   Returns a one-cycle ready/rdata completion to the granted requester.
//   Sits between the core pipeline and the memory/IO map.
// PARAMETERS
//   ADDR_WIDTH    32  byte address width, passed through unmodified
//   DATA_WIDTH    32  data word width
//   MEM_LATENCY   1   cycles from mem_en to valid mem_rdata (>=1)
//   STARVE_LIMIT  4   consecutive LS grants taken while IF waits, before IF is forced next (>=1)
// PORTS
//   clock      in   1             system clock, all state on rising edge
//   reset      in   1             synchronous, active-high
//   if_req     in   1             IF access request (read only)
//   if_addr    in   ADDR_WIDTH    IF byte address
//   if_ready   out  1             IF access complete, 1-cycle pulse
//   if_rdata   out  DATA_WIDTH    IF read data, valid only while if_ready=1
//   ls_req     in   1             LS access request
//   ls_we      in   1             1=store, 0=load
//   ls_be      in   DATA_WIDTH/8  store byte enables
//   ls_addr    in   ADDR_WIDTH    LS byte address
//   ls_wdata   in   DATA_WIDTH    store data
//   ls_ready   out  1             LS access complete, 1-cycle pulse
//   ls_rdata   out  DATA_WIDTH    LS load data, valid only while ls_ready=1
//   mem_en     out  1             memory access strobe, 1 cycle per access
//   mem_we     out  DATA_WIDTH/8  per-byte write enable (0 for reads)
//   mem_addr   out  ADDR_WIDTH    memory address, valid while mem_en=1
//   mem_wdata  out  DATA_WIDTH    memory write data, valid while mem_en=1
//   mem_rdata  in   DATA_WIDTH    memory read data, valid MEM_LATENCY cycles after mem_en
// BEHAVIOUR
//   - States: IDLE, WAIT. Owner register (IF/LS), latency counter, starve counter.
//   - While reset=1: state=IDLE, counters=0.
//     if_ready, ls_ready, mem_en and mem_we are 0; mem_addr and mem_wdata are 0.
//     Reset asserted during WAIT aborts the access: no ready pulse is produced.
//   - IDLE with any req at cycle T:
//     - Pick a winner.
//     - Drive mem_en=1, mem_addr and mem_wdata from the winner, combinationally in cycle T.
//     - mem_we = ls_be if LS wins with ls_we=1, else 0. IF always gets mem_we=0.
//     - Latch the owner, load the counter with MEM_LATENCY, go to WAIT.
//   - WAIT: counter decrements each cycle. mem_en=0 and mem_we=0.
//     - In cycle T+MEM_LATENCY, assert the owner's ready for exactly 1 cycle, then return to IDLE.
//     - The owner's rdata = mem_rdata in that cycle. Store completions also pulse ready; rdata is don't-care.
//   - No back-to-back issue. Next arbitration is at T+MEM_LATENCY+1, so throughput is 1 access per MEM_LATENCY+1 cycles.
//   - Requester rule: hold req and payload stable from assertion through the ready cycle inclusive.
//     - req may stay high after ready to request the next access.
//     - Dropping req before ready is illegal; behaviour is undefined.
//     - Inputs are ignored during WAIT.
//   - Arbitration (IDLE, both req high):
//     - LS wins by default.
//     - IF wins if starve_cnt == STARVE_LIMIT.
//   - Starve counter:
//     - +1 on each LS grant while if_req=1.
//     - Cleared on IF grant, or in any IDLE cycle with if_req=0.
//     - Saturates at STARVE_LIMIT.
//   - Single requester: always granted immediately, regardless of the counter.
//   - The non-owner's ready is never asserted. if_ready and ls_ready are never both 1.
// TESTING
//   1. reset=1 for 2 cycles, if_req=ls_req=1 -> mem_en=0, both ready=0.
//      Release at T -> LS issued at T, ls_ready at T+1.
//   2. IF only, if_addr=0x100, memory returns 0x00000013 -> cycle T: mem_en=1, mem_addr=0x100, mem_we=0.
//      Cycle T+1: if_ready=1, if_rdata=0x00000013.
//   3. if_req and ls_req rise together at T (LS load 0x200) -> LS issued T, ls_ready T+1.
//      IF issued T+2, if_ready T+3.
//   4. LS store: addr=0x204, be=4'b0011, wdata=0xDEADBEEF -> at T: mem_we=4'b0011, mem_wdata=0xDEADBEEF, mem_addr=0x204.
//      ls_ready at T+1; if_ready stays 0.
//   5. Both req held high, STARVE_LIMIT=4 -> grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
//      Each completion spaced 2 cycles apart.
//   6. MEM_LATENCY=3, IF issued at T -> if_ready at T+3 only.
//      Repeat with reset pulsed at T+2 -> no ready. After release, pending req reissued at its first IDLE cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port synchronous memory between instruction
//               fetch and load/store, one access at a time, with an IF
//               anti-starvation limit on LS priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_ready,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    ls_req,
    input  logic                    ls_we,
    input  logic [DATA_WIDTH/8-1:0] ls_be,
    input  logic [ADDR_WIDTH-1:0]   ls_addr,
    input  logic [DATA_WIDTH-1:0]   ls_wdata,
    output logic                    ls_ready,
    output logic [DATA_WIDTH-1:0]   ls_rdata,
    output logic                    mem_en,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int c_LAT_W = $clog2(MEM_LATENCY + 1);
    localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_LAT_W-1:0] c_LAT_LOAD = c_LAT_W'(MEM_LATENCY);
    localparam logic [c_STV_W-1:0] c_STV_MAX  = c_STV_W'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t               r_state,      w_state_nxt;
    logic                 r_owner_ls,   w_owner_nxt;
    logic [c_LAT_W-1:0]   r_lat_cnt,    w_lat_nxt;
    logic [c_STV_W-1:0]   r_starve_cnt, w_starve_nxt;

    logic w_any_req;
    logic w_grant_ls;
    logic w_done;

    assign w_any_req  = if_req | ls_req;
    assign w_grant_ls = ls_req & ~(if_req & (r_starve_cnt == c_STV_MAX));
    assign w_done     = (r_lat_cnt == c_LAT_W'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_owner_ls   <= 1'b0;
            r_lat_cnt    <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner_ls   <= w_owner_nxt;
            r_lat_cnt    <= w_lat_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner_ls;
        w_lat_nxt    = r_lat_cnt;
        w_starve_nxt = r_starve_cnt;
        mem_en       = 1'b0;
        mem_we       = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if_ready     = 1'b0;
        if_rdata     = '0;
        ls_ready     = 1'b0;
        ls_rdata     = '0;

        // Outputs are gated by reset so an access in flight is dropped silently.
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        mem_en      = 1'b1;
                        w_owner_nxt = w_grant_ls;
                        w_lat_nxt   = c_LAT_LOAD;
                        w_state_nxt = S_WAIT;
                        if (w_grant_ls) begin
                            mem_addr  = ls_addr;
                            mem_wdata = ls_wdata;
                            if (ls_we) begin
                                mem_we = ls_be;
                            end
                            // LS can only beat a waiting IF below the limit, so no overflow.
                            w_starve_nxt = if_req ? r_starve_cnt + c_STV_W'(1) : '0;
                        end else begin
                            mem_addr     = if_addr;
                            w_starve_nxt = '0;
                        end
                    end else begin
                        w_starve_nxt = '0;
                    end
                end
                S_WAIT: begin
                    w_lat_nxt = r_lat_cnt - c_LAT_W'(1);
                    if (w_done) begin
                        w_state_nxt = S_IDLE;
                        if (r_owner_ls) begin
                            ls_ready = 1'b1;
                            ls_rdata = mem_rdata;
                        end else begin
                            if_ready = 1'b1;
                            if_rdata = mem_rdata;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vectors, corner sequences
// and a randomized run against a transaction-level reference model.
`default_nettype none

module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, MEM_LATENCY = 1
    logic        reset, if_req, if_ready, ls_req, ls_we, ls_ready, mem_en;
    logic [31:0] if_addr, if_rdata, ls_addr, ls_wdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  ls_be, mem_we;

    // Second instance, MEM_LATENCY = 3, IF traffic only
    logic        reset3, if_req3, if_ready3, ls_req3, ls_we3, ls_ready3, mem_en3;
    logic [31:0] if_addr3, if_rdata3, ls_addr3, ls_wdata3, ls_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    logic [3:0]  ls_be3, mem_we3;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ready(ls_ready), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3), .STARVE_LIMIT(LIMIT)) dut3 (
        .clock(clk), .reset(reset3),
        .if_req(if_req3), .if_addr(if_addr3), .if_ready(if_ready3), .if_rdata(if_rdata3),
        .ls_req(ls_req3), .ls_we(ls_we3), .ls_be(ls_be3), .ls_addr(ls_addr3), .ls_wdata(ls_wdata3),
        .ls_ready(ls_ready3), .ls_rdata(ls_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3)
    );

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = i[7:0];
        if (i == 64) return 32'h0000_0013;
        return {b, 8'h5A, ~b, 8'hA5};
    endfunction

    function automatic logic [31:0] f3(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [7:0] w;
        w = 8'($urandom_range(0, 255));
        return {22'd0, w, 2'b00};
    endfunction

    // Memory behind the main instance: 256 words, one-cycle registered read
    logic [31:0] tb_mem [256];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= init_word(i);
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) tb_mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            mem_rdata <= tb_mem[mem_addr[9:2]];
        end
    end

    // Memory behind the latency-3 instance: three-stage read pipeline
    logic [31:0] p0, p1, p2;
    always @(posedge clk) begin
        p0 <= mem_en3 ? f3(mem_addr3) : 32'h0;
        p1 <= p0;
        p2 <= p1;
    end
    assign mem_rdata3 = p2;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Both requesters pending in IDLE: LS load 0x200 first, then IF fetch 0x100.
    task automatic pair_seq(input string tag);
        @(negedge clk);
        chk({tag, "_ls_issue_en"}, mem_en, 1);
        chk({tag, "_ls_issue_addr"}, mem_addr, 32'h200);
        chk({tag, "_ls_issue_we"}, mem_we, 0);
        tick();
        @(negedge clk);
        chk({tag, "_ls_ready"}, ls_ready, 1);
        chk({tag, "_if_not_ready"}, if_ready, 0);
        chk({tag, "_ls_rdata"}, ls_rdata, init_word(128));
        tick();
        ls_req = 1'b0;
        @(negedge clk);
        chk({tag, "_if_issue_en"}, mem_en, 1);
        chk({tag, "_if_issue_addr"}, mem_addr, 32'h100);
        chk({tag, "_if_issue_we"}, mem_we, 0);
        tick();
        @(negedge clk);
        chk({tag, "_if_ready"}, if_ready, 1);
        chk({tag, "_if_rdata"}, if_rdata, 32'h13);
        chk({tag, "_ls_not_ready"}, ls_ready, 0);
        tick();
        if_req = 1'b0;
    endtask

    typedef struct {
        logic        if_req;
        logic        ls_req;
        logic        ls_we;
        logic [3:0]  ls_be;
        logic [31:0] if_addr;
        logic [31:0] ls_addr;
        logic [31:0] ls_wdata;
        logic        e_en;
        logic [3:0]  e_we;
        logic [31:0] e_addr;
        logic        e_ifr;
        logic        e_lsr;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vec [9];
    logic [31:0] model_mem [256];
    bit exp_ls [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    initial begin
        vec[0] = '{0, 0, 0, 4'h0, 32'h100, 32'h200, 32'h0,        0, 4'h0, 32'h0,   0, 0, 32'h0};
        vec[1] = '{1, 0, 0, 4'hF, 32'h100, 32'h44,  32'h0,        1, 4'h0, 32'h100, 1, 0, 32'h13};
        vec[2] = '{0, 1, 1, 4'h3, 32'h100, 32'h204, 32'hDEADBEEF, 1, 4'h3, 32'h204, 0, 1, 32'h0};
        vec[3] = '{0, 1, 0, 4'hF, 32'h0,   32'h204, 32'h0,        1, 4'h0, 32'h204, 0, 1,
                   (init_word(129) & 32'hFFFF_0000) | 32'h0000_BEEF};
        vec[4] = '{0, 1, 1, 4'hF, 32'h3C,  32'h10,  32'h12345678, 1, 4'hF, 32'h10,  0, 1, 32'h0};
        vec[5] = '{0, 1, 0, 4'h0, 32'h0,   32'h10,  32'h0,        1, 4'h0, 32'h10,  0, 1, 32'h12345678};
        vec[6] = '{1, 0, 1, 4'hF, 32'h10,  32'h20,  32'hFFFFFFFF, 1, 4'h0, 32'h10,  1, 0, 32'h12345678};
        vec[7] = '{0, 1, 1, 4'h8, 32'h0,   32'h3FC, 32'hAABBCCDD, 1, 4'h8, 32'h3FC, 0, 1, 32'h0};
        vec[8] = '{0, 1, 0, 4'h0, 32'h0,   32'h3FC, 32'h0,        1, 4'h0, 32'h3FC, 0, 1,
                   (init_word(255) & 32'h00FF_FFFF) | 32'hAA00_0000};

        reset = 1'b1; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF;
        if_addr = 32'h100; ls_addr = 32'h200; ls_wdata = 32'h0;
        reset3 = 1'b1; if_req3 = 1'b0; if_addr3 = 32'h0; ls_req3 = 1'b0; ls_we3 = 1'b0;
        ls_be3 = 4'h0; ls_addr3 = 32'h0; ls_wdata3 = 32'h0;

        // Reset holds everything quiet even with both requests high
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("rst%0d_mem_en", k), mem_en, 0);
            chk($sformatf("rst%0d_mem_we", k), mem_we, 0);
            chk($sformatf("rst%0d_if_ready", k), if_ready, 0);
            chk($sformatf("rst%0d_ls_ready", k), ls_ready, 0);
        end
        tick();
        reset = 1'b0;
        reset3 = 1'b0;
        pair_seq("post_reset");
        tick();

        // Directed single-requester vectors, each from IDLE with the other side idle
        foreach (vec[i]) begin
            if_req = vec[i].if_req; ls_req = vec[i].ls_req; ls_we = vec[i].ls_we;
            ls_be = vec[i].ls_be; if_addr = vec[i].if_addr; ls_addr = vec[i].ls_addr;
            ls_wdata = vec[i].ls_wdata;
            @(negedge clk);
            chk($sformatf("v%0d_mem_en", i), mem_en, vec[i].e_en);
            chk($sformatf("v%0d_mem_we", i), mem_we, vec[i].e_we);
            if (vec[i].e_en) chk($sformatf("v%0d_mem_addr", i), mem_addr, vec[i].e_addr);
            if (vec[i].e_we != 0) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vec[i].ls_wdata);
            chk($sformatf("v%0d_issue_noready", i), {if_ready, ls_ready}, 0);
            tick();
            @(negedge clk);
            chk($sformatf("v%0d_if_ready", i), if_ready, vec[i].e_ifr);
            chk($sformatf("v%0d_ls_ready", i), ls_ready, vec[i].e_lsr);
            chk($sformatf("v%0d_wait_mem_en", i), mem_en, 0);
            if (vec[i].e_ifr) chk($sformatf("v%0d_if_rdata", i), if_rdata, vec[i].e_rdata);
            if (vec[i].e_lsr && !vec[i].ls_we) chk($sformatf("v%0d_ls_rdata", i), ls_rdata, vec[i].e_rdata);
            tick();
            if_req = 1'b0; ls_req = 1'b0;
            tick();
        end

        // Simultaneous requests without reset
        if_req = 1'b1; if_addr = 32'h100; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200;
        pair_seq("both_rise");
        tick();

        // Both held high: LS x4 then IF, completions every second cycle
        begin
            int n;
            int last;
            n = 0;
            last = -1;
            if_req = 1'b1; if_addr = 32'h100; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200;
            for (int k = 0; k < 40 && n < 10; k++) begin
                @(negedge clk);
                if (if_ready || ls_ready) begin
                    chk($sformatf("starve_order%0d", n), ls_ready, exp_ls[n]);
                    chk($sformatf("starve_excl%0d", n), if_ready & ls_ready, 0);
                    if (n > 0) chk($sformatf("starve_gap%0d", n), k - last, 2);
                    last = k;
                    n++;
                end
                tick();
            end
            if_req = 1'b0; ls_req = 1'b0;
            chk("starve_count", n, 10);
            tick();
        end

        // Latency 3: ready exactly at T+3
        if_req3 = 1'b1; if_addr3 = 32'h300;
        @(negedge clk);
        chk("lat3_issue_en", mem_en3, 1);
        chk("lat3_issue_addr", mem_addr3, 32'h300);
        for (int k = 1; k <= 3; k++) begin
            tick();
            @(negedge clk);
            chk($sformatf("lat3_ready_t%0d", k), if_ready3, k == 3);
            chk($sformatf("lat3_mem_en_t%0d", k), mem_en3, 0);
        end
        chk("lat3_rdata", if_rdata3, f3(32'h300));
        tick();
        if_req3 = 1'b0;
        tick();

        // Latency 3 with reset at T+2: aborted, then reissued once released
        if_req3 = 1'b1; if_addr3 = 32'h304;
        @(negedge clk);
        chk("abort_issue_en", mem_en3, 1);
        tick();
        @(negedge clk);
        chk("abort_t1_ready", if_ready3, 0);
        tick();
        reset3 = 1'b1;
        @(negedge clk);
        chk("abort_t2_ready", if_ready3, 0);
        chk("abort_t2_mem_en", mem_en3, 0);
        tick();
        reset3 = 1'b0;
        @(negedge clk);
        chk("abort_t3_ready", if_ready3, 0);
        chk("abort_reissue_en", mem_en3, 1);
        chk("abort_reissue_addr", mem_addr3, 32'h304);
        for (int k = 1; k <= 3; k++) begin
            tick();
            @(negedge clk);
            chk($sformatf("reissue_ready_t%0d", k), if_ready3, k == 3);
        end
        chk("reissue_rdata", if_rdata3, f3(32'h304));
        tick();
        if_req3 = 1'b0;
        tick();

        // Randomized traffic against a transaction-level model
        begin
            int next_free, done_cyc, m_starve;
            bit m_own_ls, m_store, e_en, e_ifr, e_lsr, win_ls;
            logic [31:0] m_rdata, e_addr, e_wdata;
            logic [3:0]  e_we;
            logic [7:0]  idx;
            for (int i = 0; i < 256; i++) model_mem[i] = tb_mem[i];
            next_free = 0; done_cyc = -1; m_starve = 0;
            m_own_ls = 0; m_store = 0; m_rdata = '0;
            for (int c = 0; c < 600; c++) begin
                @(negedge clk);
                e_ifr = (c == done_cyc) && !m_own_ls;
                e_lsr = (c == done_cyc) && m_own_ls;
                chk("rnd_if_ready", if_ready, e_ifr);
                chk("rnd_ls_ready", ls_ready, e_lsr);
                if (e_ifr) chk("rnd_if_rdata", if_rdata, m_rdata);
                if (e_lsr && !m_store) chk("rnd_ls_rdata", ls_rdata, m_rdata);
                e_en = 0; e_we = '0; e_addr = '0; e_wdata = '0;
                if (c >= next_free) begin
                    if (if_req || ls_req) begin
                        win_ls = ls_req && !(if_req && m_starve == LIMIT);
                        e_en = 1;
                        next_free = c + 2;
                        done_cyc = c + 1;
                        m_own_ls = win_ls;
                        m_store = win_ls && ls_we;
                        if (win_ls) begin
                            e_addr = ls_addr;
                            idx = ls_addr[9:2];
                            m_starve = if_req ? m_starve + 1 : 0;
                            if (ls_we) begin
                                e_we = ls_be;
                                e_wdata = ls_wdata;
                                for (int b = 0; b < 4; b++)
                                    if (ls_be[b]) model_mem[idx][b*8 +: 8] = ls_wdata[b*8 +: 8];
                            end else begin
                                m_rdata = model_mem[idx];
                            end
                        end else begin
                            e_addr = if_addr;
                            m_starve = 0;
                            m_rdata = model_mem[if_addr[9:2]];
                        end
                    end else begin
                        m_starve = 0;
                    end
                end
                chk("rnd_mem_en", mem_en, e_en);
                chk("rnd_mem_we", mem_we, e_we);
                if (e_en) chk("rnd_mem_addr", mem_addr, e_addr);
                if (e_we != 0) chk("rnd_mem_wdata", mem_wdata, e_wdata);
                tick();
                if (!if_req || e_ifr) begin
                    if_req = ($urandom_range(0, 2) != 0);
                    if_addr = rand_addr();
                end
                if (!ls_req || e_lsr) begin
                    ls_req = ($urandom_range(0, 3) != 0);
                    ls_we = 1'($urandom_range(0, 1));
                    ls_be = 4'($urandom_range(0, 15));
                    ls_addr = rand_addr();
                    ls_wdata = $urandom;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
